// File: rtl/mips_mdu_pkg.sv
// Shared encodings for the MIPS multiply/divide unit.
package mips_mdu_pkg;
  localparam int MDU_DATA_W = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } mdu_state_e;
endpackage

// File: rtl/mips_mdu_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
module mips_mdu_step #(
  parameter int DATA_W = 32
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] sreg,
  input  logic [DATA_W-1:0] operand,
  output logic [DATA_W-1:0] acc_next,
  output logic [DATA_W-1:0] sreg_next
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] trial;

  always_comb begin
    sum   = {1'b0, acc} + (sreg[0] ? {1'b0, operand} : '0);
    trial = {acc, sreg[DATA_W-1]};
    if (is_div) begin
      // remainder < divisor keeps the difference inside DATA_W bits
      if (trial >= {1'b0, operand}) begin
        acc_next  = trial[DATA_W-1:0] - operand;
        sreg_next = {sreg[DATA_W-2:0], 1'b1};
      end else begin
        acc_next  = trial[DATA_W-1:0];
        sreg_next = {sreg[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_next  = sum[DATA_W:1];
      sreg_next = {sum[0], sreg[DATA_W-1:1]};
    end
  end
endmodule

// File: rtl/mips_mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
module mips_mul_div_unit
  import mips_mdu_pkg::*;
#(
  parameter int DATA_W = MDU_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  mdu_state_e        state_reg;
  mdu_op_e           op_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] acc_reg, sreg_reg, opnd_reg, rs_raw_reg;
  logic              neg_q_reg, neg_r_reg, div_zero_reg;

  logic [DATA_W-1:0]   acc_next, sreg_next;
  logic [DATA_W-1:0]   abs_rs, abs_rt, q_fix, r_fix;
  logic [2*DATA_W-1:0] prod_fix;
  logic                is_signed, start_div;

  always_comb begin
    is_signed = ~op[0];
    start_div = op[1];
    abs_rs    = (is_signed && rs_data[DATA_W-1]) ? -rs_data : rs_data;
    abs_rt    = (is_signed && rt_data[DATA_W-1]) ? -rt_data : rt_data;
    prod_fix  = neg_q_reg ? -{acc_reg, sreg_reg} : {acc_reg, sreg_reg};
    q_fix     = neg_q_reg ? -sreg_reg : sreg_reg;
    r_fix     = neg_r_reg ? -acc_reg : acc_reg;
  end

  mips_mdu_step #(.DATA_W(DATA_W)) u_step (
    .is_div    (op_reg[1]),
    .acc       (acc_reg),
    .sreg      (sreg_reg),
    .operand   (opnd_reg),
    .acc_next  (acc_next),
    .sreg_next (sreg_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      op_reg       <= MDU_MULT;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      sreg_reg     <= '0;
      opnd_reg     <= '0;
      rs_raw_reg   <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      div_zero_reg <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      hi           <= '0;
      lo           <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // multiply keeps the multiplier in sreg; divide shifts the dividend out of it
            op_reg       <= mdu_op_e'(op);
            acc_reg      <= '0;
            sreg_reg     <= start_div ? abs_rs : abs_rt;
            opnd_reg     <= start_div ? abs_rt : abs_rs;
            rs_raw_reg   <= rs_data;
            neg_q_reg    <= is_signed && (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
            neg_r_reg    <= is_signed && rs_data[DATA_W-1];
            div_zero_reg <= (rt_data == '0);
            cnt_reg      <= '0;
            busy         <= 1'b1;
            state_reg    <= CALC;
          end else begin
            if (mthi) hi <= wr_data;
            if (mtlo) lo <= wr_data;
          end
        end
        CALC: begin
          acc_reg  <= acc_next;
          sreg_reg <= sreg_next;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_W'(DATA_W - 1)) state_reg <= FIX;
        end
        FIX: begin
          if (op_reg[1]) begin
            if (div_zero_reg) begin
              lo <= '1;
              hi <= rs_raw_reg;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end else begin
            {hi, lo} <= prod_fix;
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mul_div_unit.sv
// Directed bench for mips_mul_div_unit: hand-computed HI/LO results and handshake timing.
module tb_mips_mul_div_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data, rt_data, wr_data;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mips_mul_div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
    .wr_data(wr_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // inj: pulse start(DIV)+mthi mid-operation; mv: assert mthi together with start
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input bit inj, input bit mv);
    logic [31:0] hi0, lo0;
    int n;
    bit busy_ok, hold_ok;
    @(negedge clk);
    hi0 = hi; lo0 = lo;
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    mthi = mv; wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    chk({tag, "_hi_hold_e0"}, hi, hi0);
    start = 1'b0; mthi = 1'b0;
    rs_data = 32'h0BAD_0BAD; rt_data = 32'h0;
    busy_ok = 1'b1; hold_ok = 1'b1; n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
      if (inj && n == 10) begin
        start = 1'b1; op = 2'b10; mthi = 1'b1; wr_data = 32'h0000_00AA;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
    end
    start = 1'b0; mthi = 1'b0;
    chk({tag, "_latency"}, n, 33);
    chk({tag, "_busy_through"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_hilo_stable"}, {31'd0, hold_ok}, 32'd1);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    $display("op %s: op=%b rs=%h rt=%h -> hi=%h lo=%h latency=%0d", tag, o, a, b, hi, lo, n);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    mthi = 1'b0; mtlo = 1'b0; wr_data = '0;
    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    $display("reset: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
    run_op("div_negdiv", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0, 0);
    run_op("divu", 2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 0, 0);
    run_op("div_zero", 2'b10, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0);
    run_op("divu_zero", 2'b11, 32'h8765_4321, 32'h0000_0000, 32'h8765_4321, 32'hFFFF_FFFF, 0, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0);
    run_op("busy_ignore", 2'b01, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 32'h0000_001E, 1, 0);

    // asynchronous reset part-way through an operation
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_data = 32'd9; rt_data = 32'd9;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    $display("mid-op reset: busy=%b hi=%h lo=%h", busy, hi, lo);
    @(negedge clk); rst_n = 1'b1;
    run_op("after_rst", 2'b01, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 32'h0000_0051, 0, 0);

    // idle MTLO
    @(negedge clk);
    mtlo = 1'b1; wr_data = 32'h0000_0055;
    @(posedge clk); #1;
    chk("mtlo_lo", lo, 32'h0000_0055);
    chk("mtlo_hi", hi, 32'h0000_0000);
    chk("mtlo_done", {31'd0, done}, 32'd0);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    mtlo = 1'b0;
    $display("mtlo: hi=%h lo=%h done=%b", hi, lo, done);

    // MTHI and MTLO together
    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; wr_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    chk("mthilo_hi", hi, 32'hCAFE_F00D);
    chk("mthilo_lo", lo, 32'hCAFE_F00D);
    chk("mthilo_done", {31'd0, done}, 32'd0);
    mthi = 1'b0; mtlo = 1'b0;
    $display("mthi+mtlo: hi=%h lo=%h done=%b", hi, lo, done);

    run_op("start_mthi", 2'b01, 32'h0000_0002, 32'h0000_0003, 32'h0000_0000, 32'h0000_0006, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
